// File: rtl/apb_bridge_pkg.sv
// rtl/apb_bridge_pkg.sv - shared types and helpers for the APB-to-APB bridge
//
// Purpose : bridge FSM state encoding, slot-index width and the wait-counter
//           width helper used by apb_bridge_sc.
// Ports   : none (package).
package apb_bridge_pkg;

  localparam int SLOT_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Counter only has to reach TIMEOUT-1; keep at least one bit so the
  // disabled (TIMEOUT=0) and TIMEOUT=1 cases still elaborate.
  function automatic int wait_cnt_width(input int timeout);
    int w;
    w = $clog2(timeout);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/apb_bridge_slot_decode.sv
// rtl/apb_bridge_slot_decode.sv - slot index decode and mapped check
//
// Purpose : turns the 4-bit address slot field into a mapped flag and a
//           one-hot slave select (all zero when the slot is unmapped).
// Ports   : sel_field  in  SLOT_IDX_W  slot field taken from the master address
//           mapped     out 1           slot exists and is enabled in SLOT_MASK
//           sel_onehot out NUM_SLOTS   one-hot select for the addressed slot
module apb_bridge_slot_decode
  import apb_bridge_pkg::*;
#(
  parameter int          NUM_SLOTS = 16,
  parameter logic [15:0] SLOT_MASK = 16'hFFFF
) (
  input  logic [SLOT_IDX_W-1:0] sel_field,
  output logic                  mapped,
  output logic [NUM_SLOTS-1:0]  sel_onehot
);

  always_comb begin
    mapped = (32'(sel_field) < 32'(NUM_SLOTS)) && SLOT_MASK[sel_field];
    for (int i = 0; i < NUM_SLOTS; i++) begin
      sel_onehot[i] = mapped && (sel_field == SLOT_IDX_W'(i));
    end
  end

endmodule

// File: rtl/apb_bridge_sc.sv
// rtl/apb_bridge_sc.sv - single-clock APB master-to-multi-slave bridge
//
// Purpose : accepts one APB master transfer, replays it on the selected slave
//           slot, returns the slave response as a one-cycle PREADY_M pulse.
//           Unmapped slots error immediately; slow slaves are aborted after
//           TIMEOUT ACCESS cycles; error responses are counted (saturating).
// Ports   : PCLK/PRESET              clock, synchronous active-high reset
//           PSEL_M..PWDATA_M         master request inputs
//           PRDATA_M/PREADY_M/PSLVERR_M  registered master response
//           PSEL_S..PWDATA_S         registered slave request outputs
//           PRDATA_S/PREADY_S/PSLVERR_S  shared slave response inputs
//           TIMEOUT_EVT              pulse with PREADY_M on a timeout abort
//           ERR_COUNT                saturating count of error responses
module apb_bridge_sc
  import apb_bridge_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 32,
  parameter int          NUM_SLOTS  = 16,
  parameter int          SEL_LSB    = 24,
  parameter logic [15:0] SLOT_MASK  = 16'hFFFF,
  parameter int          TIMEOUT    = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL_M,
  input  logic [ADDR_WIDTH-1:0] PADDR_M,
  input  logic                  PWRITE_M,
  input  logic                  PENABLE_M,
  input  logic [DATA_WIDTH-1:0] PWDATA_M,
  output logic [DATA_WIDTH-1:0] PRDATA_M,
  output logic                  PREADY_M,
  output logic                  PSLVERR_M,
  output logic [NUM_SLOTS-1:0]  PSEL_S,
  output logic [ADDR_WIDTH-1:0] PADDR_S,
  output logic                  PWRITE_S,
  output logic                  PENABLE_S,
  output logic [DATA_WIDTH-1:0] PWDATA_S,
  input  logic [DATA_WIDTH-1:0] PRDATA_S,
  input  logic                  PREADY_S,
  input  logic                  PSLVERR_S,
  output logic                  TIMEOUT_EVT,
  output logic [7:0]            ERR_COUNT
);

  localparam int             CNT_W     = wait_cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t               state;
  logic [CNT_W-1:0]     wait_cnt;
  logic                 slot_mapped;
  logic [NUM_SLOTS-1:0] slot_sel;
  logic                 setup_req;

  apb_bridge_slot_decode #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_MASK (SLOT_MASK)
  ) u_slot_decode (
    .sel_field  (PADDR_M[SEL_LSB+SLOT_IDX_W-1:SEL_LSB]),
    .mapped     (slot_mapped),
    .sel_onehot (slot_sel)
  );

  assign setup_req = PSEL_M && !PENABLE_M;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      PRDATA_M    <= '0;
      PREADY_M    <= 1'b0;
      PSLVERR_M   <= 1'b0;
      PSEL_S      <= '0;
      PADDR_S     <= '0;
      PWRITE_S    <= 1'b0;
      PENABLE_S   <= 1'b0;
      PWDATA_S    <= '0;
      TIMEOUT_EVT <= 1'b0;
      ERR_COUNT   <= '0;
    end else begin
      // Pulses default low; set only on the edge that enters RESP.
      PREADY_M    <= 1'b0;
      TIMEOUT_EVT <= 1'b0;
      case (state)
        IDLE: begin
          if (setup_req) begin
            if (slot_mapped) begin
              state    <= SETUP;
              PSEL_S   <= slot_sel;
              PADDR_S  <= PADDR_M;
              PWRITE_S <= PWRITE_M;
              PWDATA_S <= PWRITE_M ? PWDATA_M : '0;
            end else begin
              // Unmapped: answer straight away without touching any slave.
              state     <= RESP;
              PREADY_M  <= 1'b1;
              PSLVERR_M <= 1'b1;
              PRDATA_M  <= '0;
            end
          end
        end
        SETUP: begin
          PENABLE_S <= 1'b1;
          wait_cnt  <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          // Slave ready wins over a timeout reached on the same edge.
          if (PREADY_S || ((TIMEOUT != 0) && (wait_cnt == CNT_LIMIT))) begin
            state     <= RESP;
            PREADY_M  <= 1'b1;
            PSLVERR_M <= PREADY_S ? PSLVERR_S : 1'b1;
            PRDATA_M  <= PREADY_S ? PRDATA_S : '0;
            TIMEOUT_EVT <= !PREADY_S;
            PSEL_S    <= '0;
            PENABLE_S <= 1'b0;
            PADDR_S   <= '0;
            PWRITE_S  <= 1'b0;
            PWDATA_S  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          // PSLVERR_M still holds this transfer's error flag here.
          if (PSLVERR_M && (ERR_COUNT != 8'hFF)) begin
            ERR_COUNT <= ERR_COUNT + 8'd1;
          end
          PSLVERR_M <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_bridge_sc.sv
// tb/tb_apb_bridge_sc.sv - directed self-checking bench for apb_bridge_sc
module tb_apb_bridge_sc;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSEL_M;
  logic [31:0] PADDR_M;
  logic        PWRITE_M;
  logic        PENABLE_M;
  logic [31:0] PWDATA_M;
  logic [31:0] PRDATA_M;
  logic        PREADY_M;
  logic        PSLVERR_M;
  logic [7:0]  PSEL_S;
  logic [31:0] PADDR_S;
  logic        PWRITE_S;
  logic        PENABLE_S;
  logic [31:0] PWDATA_S;
  logic [31:0] PRDATA_S;
  logic        PREADY_S;
  logic        PSLVERR_S;
  logic        TIMEOUT_EVT;
  logic [7:0]  ERR_COUNT;

  int n_tests = 0;
  int n_fail  = 0;

  // Slave responder configuration
  int          cfg_waits = 0;
  logic [31:0] cfg_rdata = '0;
  logic        cfg_err   = 1'b0;
  logic        cfg_never = 1'b0;
  int          wcnt      = 0;

  // Per-transfer observations
  int          lat;
  logic [31:0] rd;
  logic        err;
  logic        tevt;
  logic [7:0]  obs_psel;
  logic        obs_pen_first;
  logic [31:0] obs_paddr;
  logic [31:0] obs_pwdata;
  logic        obs_pwrite;
  logic [7:0]  psel_or;
  int          acc_cycles;
  int          ecount = 0;

  apb_bridge_sc #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .NUM_SLOTS  (8),
    .SEL_LSB    (24),
    .SLOT_MASK  (16'hFF7F),
    .TIMEOUT    (8)
  ) dut (
    .PCLK        (PCLK),
    .PRESET      (PRESET),
    .PSEL_M      (PSEL_M),
    .PADDR_M     (PADDR_M),
    .PWRITE_M    (PWRITE_M),
    .PENABLE_M   (PENABLE_M),
    .PWDATA_M    (PWDATA_M),
    .PRDATA_M    (PRDATA_M),
    .PREADY_M    (PREADY_M),
    .PSLVERR_M   (PSLVERR_M),
    .PSEL_S      (PSEL_S),
    .PADDR_S     (PADDR_S),
    .PWRITE_S    (PWRITE_S),
    .PENABLE_S   (PENABLE_S),
    .PWDATA_S    (PWDATA_S),
    .PRDATA_S    (PRDATA_S),
    .PREADY_S    (PREADY_S),
    .PSLVERR_S   (PSLVERR_S),
    .TIMEOUT_EVT (TIMEOUT_EVT),
    .ERR_COUNT   (ERR_COUNT)
  );

  always #5 PCLK = ~PCLK;

  // Slave: PREADY_S after cfg_waits ACCESS cycles, driven mid-cycle.
  always @(negedge PCLK) begin
    if ((PSEL_S != '0) && PENABLE_S && !cfg_never) begin
      if (wcnt == cfg_waits) begin
        PREADY_S  = 1'b1;
        PRDATA_S  = cfg_rdata;
        PSLVERR_S = cfg_err;
      end else begin
        PREADY_S  = 1'b0;
        PRDATA_S  = 32'hBAD0_BAD0;
        PSLVERR_S = 1'b0;
      end
      wcnt++;
    end else begin
      PREADY_S  = 1'b0;
      PRDATA_S  = 32'hBAD0_BAD0;
      PSLVERR_S = 1'b0;
      wcnt      = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One master transfer; lat = edges after the setup edge until PREADY_M is seen.
  task automatic master_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd);
    @(posedge PCLK);
    #1;
    PSEL_M = 1'b1; PENABLE_M = 1'b0; PADDR_M = addr; PWRITE_M = wr; PWDATA_M = wd;
    @(posedge PCLK);
    #1;
    PENABLE_M = 1'b1;
    lat = -1; rd = 'x; err = 1'bx; tevt = 1'bx; psel_or = '0; acc_cycles = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge PCLK);
      psel_or = psel_or | PSEL_S;
      if (PENABLE_S) acc_cycles++;
      if (k == 1) begin
        obs_psel = PSEL_S; obs_pen_first = PENABLE_S; obs_paddr = PADDR_S;
        obs_pwdata = PWDATA_S; obs_pwrite = PWRITE_S;
      end
      if (PREADY_M) begin
        lat = k; rd = PRDATA_M; err = PSLVERR_M; tevt = TIMEOUT_EVT;
        break;
      end
    end
    @(posedge PCLK);
    #1;
    PSEL_M = 1'b0; PENABLE_M = 1'b0;
  endtask

  task automatic bump_err();
    if (ecount < 255) ecount++;
  endtask

  initial begin
    PRESET = 1'b1; PSEL_M = 1'b0; PADDR_M = '0; PWRITE_M = 1'b0;
    PENABLE_M = 1'b0; PWDATA_M = '0;
    PREADY_S = 1'b0; PRDATA_S = '0; PSLVERR_S = 1'b0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_psel_s", 32'(PSEL_S), 32'h0);
    check("rst_penable_s", 32'(PENABLE_S), 32'h0);
    check("rst_pready_m", 32'(PREADY_M), 32'h0);
    check("rst_pslverr_m", 32'(PSLVERR_M), 32'h0);
    check("rst_prdata_m", PRDATA_M, 32'h0);
    check("rst_paddr_s", PADDR_S, 32'h0);
    check("rst_err_count", 32'(ERR_COUNT), 32'h0);
    check("rst_timeout_evt", 32'(TIMEOUT_EVT), 32'h0);
    @(posedge PCLK);
    #1 PRESET = 1'b0;

    // Zero-wait write to slot 3
    cfg_waits = 0; cfg_err = 1'b0; cfg_rdata = 32'h0;
    master_xfer(32'h0300_0010, 1'b1, 32'hDEAD_BEEF);
    check("wr_psel_s", 32'(obs_psel), 32'h0000_0008);
    check("wr_penable_setup", 32'(obs_pen_first), 32'h0);
    check("wr_paddr_s", obs_paddr, 32'h0300_0010);
    check("wr_pwdata_s", obs_pwdata, 32'hDEAD_BEEF);
    check("wr_pwrite_s", 32'(obs_pwrite), 32'h1);
    check("wr_latency", 32'(lat), 32'd3);
    check("wr_pslverr", 32'(err), 32'h0);
    check("wr_err_count", 32'(ERR_COUNT), 32'(ecount));

    // Read slot 5, 3 waits, slave error
    cfg_waits = 3; cfg_err = 1'b1; cfg_rdata = 32'h1234_5678;
    master_xfer(32'h0500_0020, 1'b0, 32'hFFFF_FFFF);
    bump_err();
    check("rd5_psel_s", 32'(obs_psel), 32'h0000_0020);
    check("rd5_pwdata_zero", obs_pwdata, 32'h0);
    check("rd5_latency", 32'(lat), 32'd6);
    check("rd5_prdata", rd, 32'h1234_5678);
    check("rd5_pslverr", 32'(err), 32'h1);
    check("rd5_access_cycles", 32'(acc_cycles), 32'd4);
    check("rd5_err_count", 32'(ERR_COUNT), 32'(ecount));
    @(negedge PCLK);
    check("rd5_prdata_hold", PRDATA_M, 32'h1234_5678);
    check("rd5_pslverr_low", 32'(PSLVERR_M), 32'h0);

    // Slot 9 beyond NUM_SLOTS
    master_xfer(32'h0900_0000, 1'b1, 32'h0000_1111);
    bump_err();
    check("unm9_latency", 32'(lat), 32'd1);
    check("unm9_pslverr", 32'(err), 32'h1);
    check("unm9_prdata", rd, 32'h0);
    check("unm9_no_psel", 32'(psel_or), 32'h0);
    check("unm9_err_count", 32'(ERR_COUNT), 32'(ecount));

    // Slot 7 masked off
    master_xfer(32'h0700_0004, 1'b0, 32'h0);
    bump_err();
    check("msk7_latency", 32'(lat), 32'd1);
    check("msk7_no_psel", 32'(psel_or), 32'h0);
    check("msk7_err_count", 32'(ERR_COUNT), 32'(ecount));

    // Zero-wait read slot 2
    cfg_waits = 0; cfg_err = 1'b0; cfg_rdata = 32'hA5A5_0F0F;
    master_xfer(32'h0200_0100, 1'b0, 32'h0);
    check("rd2_latency", 32'(lat), 32'd3);
    check("rd2_prdata", rd, 32'hA5A5_0F0F);
    check("rd2_pslverr", 32'(err), 32'h0);

    // Ready on the same edge as the timeout limit: success
    cfg_waits = 7; cfg_rdata = 32'h0BAD_F00D;
    master_xfer(32'h0600_0000, 1'b0, 32'h0);
    check("w7_latency", 32'(lat), 32'd10);
    check("w7_prdata", rd, 32'h0BAD_F00D);
    check("w7_timeout_evt", 32'(tevt), 32'h0);
    check("w7_pslverr", 32'(err), 32'h0);

    // Slave never ready: timeout abort
    cfg_never = 1'b1;
    master_xfer(32'h0100_0000, 1'b1, 32'h5555_AAAA);
    bump_err();
    check("to_latency", 32'(lat), 32'd10);
    check("to_timeout_evt", 32'(tevt), 32'h1);
    check("to_prdata", rd, 32'h0);
    check("to_pslverr", 32'(err), 32'h1);
    check("to_access_cycles", 32'(acc_cycles), 32'd8);
    check("to_err_count", 32'(ERR_COUNT), 32'(ecount));
    @(negedge PCLK);
    check("to_evt_low", 32'(TIMEOUT_EVT), 32'h0);
    cfg_never = 1'b0;

    // Saturation over 300 error transfers
    for (int i = 0; i < 300; i++) begin
      master_xfer(32'h0F00_0000, 1'b0, 32'h0);
      bump_err();
      if (ecount == 254 && i < 299) check("sat_254", 32'(ERR_COUNT), 32'd254);
    end
    check("sat_err_count", 32'(ERR_COUNT), 32'd255);

    // Reset while in ACCESS
    cfg_never = 1'b1;
    @(posedge PCLK);
    #1;
    PSEL_M = 1'b1; PENABLE_M = 1'b0; PADDR_M = 32'h0200_0000; PWRITE_M = 1'b1; PWDATA_M = 32'h7777_7777;
    @(posedge PCLK);
    #1 PENABLE_M = 1'b1;
    @(posedge PCLK);
    @(negedge PCLK);
    check("mid_in_access", 32'(PENABLE_S), 32'h1);
    @(posedge PCLK);
    #1;
    PRESET = 1'b1; PSEL_M = 1'b0; PENABLE_M = 1'b0;
    @(posedge PCLK);
    @(negedge PCLK);
    check("mid_psel_s", 32'(PSEL_S), 32'h0);
    check("mid_penable_s", 32'(PENABLE_S), 32'h0);
    check("mid_paddr_s", PADDR_S, 32'h0);
    check("mid_pwdata_s", PWDATA_S, 32'h0);
    check("mid_pready_m", 32'(PREADY_M), 32'h0);
    check("mid_prdata_m", PRDATA_M, 32'h0);
    check("mid_err_count", 32'(ERR_COUNT), 32'h0);
    ecount = 0;
    @(posedge PCLK);
    #1 PRESET = 1'b0;
    begin
      logic ready_seen;
      ready_seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
        @(negedge PCLK);
        ready_seen = ready_seen | PREADY_M | (PSEL_S != '0);
      end
      check("mid_no_activity", 32'(ready_seen), 32'h0);
    end
    cfg_never = 1'b0;

    // Normal transfer after reset
    cfg_waits = 1; cfg_err = 1'b0; cfg_rdata = 32'h0;
    master_xfer(32'h0400_0040, 1'b1, 32'hCAFE_0001);
    check("post_psel_s", 32'(obs_psel), 32'h0000_0010);
    check("post_pwdata_s", obs_pwdata, 32'hCAFE_0001);
    check("post_latency", 32'(lat), 32'd4);
    check("post_pslverr", 32'(err), 32'h0);
    check("post_err_count", 32'(ERR_COUNT), 32'(ecount));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
